// File: rtl/pc_unit_if.sv
// Fetch-side bundle for the program-counter unit: control inputs from decode
// and branch-compare, PC and exception outputs toward fetch and trap logic.
interface pc_unit_if #(parameter int XLEN = 32);
   logic            advance;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] rs1_data;
   logic            is_branch;
   logic            is_jal;
   logic            is_jalr;
   logic            branch_taken;
   logic            is_compressed;
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic [XLEN-1:0] pc_link;
   logic            exc_valid;
   logic [XLEN-1:0] exc_pc;
   logic [XLEN-1:0] exc_tval;
   logic            halted;

   modport master (
      output advance, redirect_valid, redirect_pc, imm, rs1_data,
             is_branch, is_jal, is_jalr, branch_taken, is_compressed,
      input  pc, pc_valid, pc_link, exc_valid, exc_pc, exc_tval, halted
   );

   modport slave (
      input  advance, redirect_valid, redirect_pc, imm, rs1_data,
             is_branch, is_jal, is_jalr, branch_taken, is_compressed,
      output pc, pc_valid, pc_link, exc_valid, exc_pc, exc_tval, halted
   );
endinterface

// File: rtl/pc_unit.sv
// Registered PC generator: picks the next fetch address, traps misaligned
// targets to a fixed vector and halts after too many back-to-back faults.
module pc_unit #(
   parameter int              XLEN             = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR     = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR      = 32'h0000_0100,
   parameter int              IALIGN           = 32,
   parameter int              MAX_NESTED_TRAPS = 2
) (
   input logic       clk,
   input logic       rst,
   pc_unit_if.slave  bus
);
   localparam int NW = $clog2(MAX_NESTED_TRAPS + 1);

   typedef enum logic [1:0] {BOOT, RUN, TRAP, HALTED} state_t;

   state_t          state_q, state_nxt;
   logic [XLEN-1:0] pc_q, pc_nxt;
   logic [XLEN-1:0] exc_pc_q, exc_pc_nxt;
   logic [XLEN-1:0] exc_tval_q, exc_tval_nxt;
   logic [NW-1:0]   nest_q, nest_nxt, nest_inc;

   logic [XLEN-1:0] len, seq_pc, jalr_t, target;
   logic            misal, step;

   always_comb begin
      len    = (IALIGN == 16 && bus.is_compressed) ? XLEN'(2) : XLEN'(4);
      seq_pc = pc_q + len;
      jalr_t = (bus.rs1_data + bus.imm) & ~XLEN'(1);
      if (bus.redirect_valid)                   target = bus.redirect_pc;
      else if (bus.is_jalr)                     target = jalr_t;
      else if (bus.is_jal)                      target = pc_q + bus.imm;
      else if (bus.is_branch && bus.branch_taken) target = pc_q + bus.imm;
      else                                      target = seq_pc;
      misal    = (IALIGN == 16) ? target[0] : (target[1:0] != 2'b00);
      step     = bus.redirect_valid | bus.advance;
      nest_inc = nest_q + 1'b1;
   end

   always_comb begin
      state_nxt    = state_q;
      pc_nxt       = pc_q;
      exc_pc_nxt   = exc_pc_q;
      exc_tval_nxt = exc_tval_q;
      nest_nxt     = nest_q;
      case (state_q)
         BOOT: state_nxt = RUN;
         RUN: begin
            if (step) begin
               if (!misal) begin
                  pc_nxt   = target;
                  nest_nxt = '0;
               end else begin
                  exc_pc_nxt   = pc_q;
                  exc_tval_nxt = target;
                  pc_nxt       = TRAP_VECTOR;
                  nest_nxt     = nest_inc;
                  state_nxt    = (nest_inc == NW'(MAX_NESTED_TRAPS)) ? HALTED : TRAP;
               end
            end
         end
         // one-cycle fetch bubble; redirects are deliberately dropped here
         TRAP:    state_nxt = RUN;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VECTOR;
         exc_pc_q   <= '0;
         exc_tval_q <= '0;
         nest_q     <= '0;
      end else begin
         state_q    <= state_nxt;
         pc_q       <= pc_nxt;
         exc_pc_q   <= exc_pc_nxt;
         exc_tval_q <= exc_tval_nxt;
         nest_q     <= nest_nxt;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.pc_link   = seq_pc;
   assign bus.pc_valid  = (state_q == RUN);
   assign bus.exc_valid = (state_q == TRAP);
   assign bus.halted    = (state_q == HALTED);
   assign bus.exc_pc    = exc_pc_q;
   assign bus.exc_tval  = exc_tval_q;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && state_q == RUN &&
          ((IALIGN == 16) ? pc_q[0] : (pc_q[1:0] != 2'b00)))
         $fatal(1, "pc_unit: misaligned pc %h while valid", pc_q);
      if (!rst && state_q == RUN && bus.advance === 1'b1 &&
          $isunknown({bus.redirect_valid, bus.is_branch, bus.is_jal,
                      bus.is_jalr, bus.branch_taken, bus.is_compressed}))
         $fatal(1, "pc_unit: unknown control inputs while advancing");
   end
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: one IALIGN=32 instance and one IALIGN=16 instance.
module tb_pc_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   pc_unit_if #(.XLEN(32)) b32 ();
   pc_unit_if #(.XLEN(32)) b16 ();

   pc_unit #(.IALIGN(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
   pc_unit #(.IALIGN(16)) u16 (.clk(clk), .rst(rst), .bus(b16));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr32();
      b32.advance = 0; b32.redirect_valid = 0; b32.redirect_pc = 0;
      b32.imm = 0; b32.rs1_data = 0; b32.is_branch = 0; b32.is_jal = 0;
      b32.is_jalr = 0; b32.branch_taken = 0; b32.is_compressed = 0;
   endtask

   task automatic clr16();
      b16.advance = 0; b16.redirect_valid = 0; b16.redirect_pc = 0;
      b16.imm = 0; b16.rs1_data = 0; b16.is_branch = 0; b16.is_jal = 0;
      b16.is_jalr = 0; b16.branch_taken = 0; b16.is_compressed = 0;
   endtask

   task automatic goto32(input logic [31:0] a);
      clr32();
      b32.redirect_valid = 1; b32.redirect_pc = a;
      tick();
      clr32();
   endtask

   task automatic test_reset();
      clr32(); clr16();
      rst = 1;
      tick(); tick();
      total++; if (b32.pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", b32.pc, 32'h0); end
      total++; if ({b32.pc_valid, b32.exc_valid, b32.halted} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {b32.pc_valid, b32.exc_valid, b32.halted}); end
      total++; if ({b32.exc_pc, b32.exc_tval} !== 64'h0) begin bad++; $display("FAIL reset_exc got=%h want=0", {b32.exc_pc, b32.exc_tval}); end
      rst = 0;
      b32.advance = 1;
      #1;
      total++; if (b32.pc_valid !== 1'b0) begin bad++; $display("FAIL boot_valid got=%b want=0", b32.pc_valid); end
      tick();
      total++; if (b32.pc !== 32'h0 || b32.pc_valid !== 1'b1) begin bad++; $display("FAIL boot_exit pc=%h v=%b want=0/1", b32.pc, b32.pc_valid); end
      tick();
      total++; if (b32.pc !== 32'h4) begin bad++; $display("FAIL seq_4 got=%h want=%h", b32.pc, 32'h4); end
      tick();
      total++; if (b32.pc !== 32'h8) begin bad++; $display("FAIL seq_8 got=%h want=%h", b32.pc, 32'h8); end
      clr32();
   endtask

   task automatic test_wrap();
      goto32(32'hFFFF_FFFC);
      #1;
      total++; if (b32.pc_link !== 32'h0) begin bad++; $display("FAIL wrap_link got=%h want=0", b32.pc_link); end
      b32.advance = 1;
      tick();
      total++; if (b32.pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h want=0", b32.pc); end
      clr32();
   endtask

   task automatic test_branch_jump();
      goto32(32'h40);
      b32.advance = 1; b32.is_branch = 1; b32.branch_taken = 1; b32.imm = 32'h10;
      tick();
      total++; if (b32.pc !== 32'h50) begin bad++; $display("FAIL br_taken got=%h want=%h", b32.pc, 32'h50); end
      goto32(32'h40);
      b32.advance = 1; b32.is_branch = 1; b32.branch_taken = 0; b32.imm = 32'h10;
      tick();
      total++; if (b32.pc !== 32'h44) begin bad++; $display("FAIL br_not_taken got=%h want=%h", b32.pc, 32'h44); end
      goto32(32'h40);
      b32.advance = 1; b32.is_jal = 1; b32.imm = 32'hFFFF_FFF8;
      tick();
      total++; if (b32.pc !== 32'h38) begin bad++; $display("FAIL jal_neg got=%h want=%h", b32.pc, 32'h38); end
      goto32(32'h40);
      b32.advance = 1; b32.is_jalr = 1; b32.rs1_data = 32'h201; b32.imm = 32'h3;
      b32.is_compressed = 1;
      #1;
      total++; if (b32.pc_link !== 32'h44) begin bad++; $display("FAIL jalr_link got=%h want=%h", b32.pc_link, 32'h44); end
      tick();
      total++; if (b32.pc !== 32'h204 || b32.exc_valid !== 1'b0) begin bad++; $display("FAIL jalr_pc got=%h exc=%b want=204/0", b32.pc, b32.exc_valid); end
      clr32();
   endtask

   task automatic test_stall_redirect();
      goto32(32'h60);
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (b32.pc !== 32'h60) begin bad++; $display("FAIL stall_%0d got=%h want=%h", i, b32.pc, 32'h60); end
      end
      b32.redirect_valid = 1; b32.redirect_pc = 32'h80; b32.is_jal = 1; b32.imm = 32'h20;
      tick();
      total++; if (b32.pc !== 32'h80) begin bad++; $display("FAIL redirect_pri got=%h want=%h", b32.pc, 32'h80); end
      clr32();
   endtask

   task automatic test_trap_nest();
      goto32(32'h40);
      b32.advance = 1; b32.is_jal = 1; b32.imm = 32'h6;
      tick();
      total++; if (b32.exc_valid !== 1'b1 || b32.pc_valid !== 1'b0) begin bad++; $display("FAIL trap_flags exc=%b v=%b want=1/0", b32.exc_valid, b32.pc_valid); end
      total++; if (b32.exc_pc !== 32'h40 || b32.exc_tval !== 32'h46) begin bad++; $display("FAIL trap_info epc=%h tval=%h want=40/46", b32.exc_pc, b32.exc_tval); end
      clr32();
      b32.redirect_valid = 1; b32.redirect_pc = 32'h80;
      tick();
      clr32();
      total++; if (b32.pc !== 32'h100 || b32.pc_valid !== 1'b1 || b32.exc_valid !== 1'b0) begin bad++; $display("FAIL trap_exit pc=%h v=%b exc=%b want=100/1/0", b32.pc, b32.pc_valid, b32.exc_valid); end
      // good advance clears the nest count, so the next fault only traps
      b32.advance = 1;
      tick();
      b32.is_jal = 1; b32.imm = 32'h2;
      tick();
      total++; if (b32.exc_valid !== 1'b1 || b32.halted !== 1'b0 || b32.exc_tval !== 32'h106) begin bad++; $display("FAIL retrap exc=%b h=%b tval=%h want=1/0/106", b32.exc_valid, b32.halted, b32.exc_tval); end
      clr32();
      tick();
      b32.advance = 1; b32.is_jalr = 1; b32.rs1_data = 32'h101; b32.imm = 32'h2;
      tick();
      total++; if (b32.halted !== 1'b1 || b32.pc_valid !== 1'b0 || b32.exc_valid !== 1'b0) begin bad++; $display("FAIL halt_flags h=%b v=%b exc=%b want=1/0/0", b32.halted, b32.pc_valid, b32.exc_valid); end
      total++; if (b32.pc !== 32'h100 || b32.exc_pc !== 32'h100 || b32.exc_tval !== 32'h102) begin bad++; $display("FAIL halt_info pc=%h epc=%h tval=%h want=100/100/102", b32.pc, b32.exc_pc, b32.exc_tval); end
      clr32();
      b32.redirect_valid = 1; b32.redirect_pc = 32'h40; b32.advance = 1;
      tick(); tick();
      total++; if (b32.halted !== 1'b1 || b32.pc !== 32'h100 || b32.exc_tval !== 32'h102) begin bad++; $display("FAIL halt_sticky h=%b pc=%h tval=%h want=1/100/102", b32.halted, b32.pc, b32.exc_tval); end
      clr32();
      rst = 1;
      #1;
      total++; if (b32.pc !== 32'h0 || b32.halted !== 1'b0) begin bad++; $display("FAIL halt_recover pc=%h h=%b want=0/0", b32.pc, b32.halted); end
      tick();
      rst = 0;
      tick();
   endtask

   task automatic test_ialign16();
      clr16();
      b16.redirect_valid = 1; b16.redirect_pc = 32'h10;
      tick();
      clr16();
      b16.advance = 1; b16.is_compressed = 1;
      #1;
      total++; if (b16.pc_link !== 32'h12) begin bad++; $display("FAIL c_link got=%h want=%h", b16.pc_link, 32'h12); end
      tick();
      total++; if (b16.pc !== 32'h12) begin bad++; $display("FAIL c_step got=%h want=%h", b16.pc, 32'h12); end
      b16.is_branch = 1; b16.branch_taken = 1; b16.imm = 32'h2;
      tick();
      total++; if (b16.pc !== 32'h14 || b16.exc_valid !== 1'b0 || b16.pc_valid !== 1'b1) begin bad++; $display("FAIL c_branch pc=%h exc=%b v=%b want=14/0/1", b16.pc, b16.exc_valid, b16.pc_valid); end
      clr16();
      #1;
      total++; if (b16.pc_link !== 32'h18) begin bad++; $display("FAIL full_link got=%h want=%h", b16.pc_link, 32'h18); end
      b16.redirect_valid = 1; b16.redirect_pc = 32'h15;
      tick();
      clr16();
      total++; if (b16.exc_valid !== 1'b1 || b16.exc_tval !== 32'h15 || b16.exc_pc !== 32'h14) begin bad++; $display("FAIL c_trap exc=%b tval=%h epc=%h want=1/15/14", b16.exc_valid, b16.exc_tval, b16.exc_pc); end
      tick();
      total++; if (b16.pc !== 32'h100 || b16.pc_valid !== 1'b1) begin bad++; $display("FAIL c_trap_exit pc=%h v=%b want=100/1", b16.pc, b16.pc_valid); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_wrap();
      test_branch_jump();
      test_stall_redirect();
      test_trap_nest();
      test_ialign16();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
